// File: rtl/neureka_package.sv
// Shared types and constants for the neureka load path.
// The load-channel arbiter's mode enum and status flags live here.
package neureka_package;

    localparam int NEUREKA_MEM_BANDWIDTH_EXT = 256;

    // Wide enough for any supported ID FIFO depth (up to 128 entries).
    localparam int LD_ARB_CNT_W = 8;

    typedef enum logic {
        ARB_FIXED = 1'b0,
        ARB_RR    = 1'b1
    } arb_mode_t;

    typedef struct packed {
        logic [LD_ARB_CNT_W-1:0] outstanding;
        logic                    fifo_empty;
        logic                    fifo_full;
        logic                    err_underflow;
    } ld_arb_flags_t;

endpackage

// File: rtl/neureka_id_fifo.sv
// Small FIFO that holds the channel IDs of issued loads.
// Responses come back in order, so the head is always the next consumer.
module neureka_id_fifo #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 2,
    parameter int CNTW  = $clog2(DEPTH) + 1
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             clear_i,
    input  logic             push_i,
    input  logic [WIDTH-1:0] data_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] data_o,
    output logic             full_o,
    output logic             empty_o,
    output logic [CNTW-1:0]  count_o
);

    localparam int PW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]    wr_ptr_q, rd_ptr_q;
    logic [CNTW-1:0]  cnt_q;
    logic             push_ok, pop_ok;

    assign full_o  = (cnt_q == CNTW'(DEPTH));
    assign empty_o = (cnt_q == '0);
    assign count_o = cnt_q;
    assign data_o  = mem_q[rd_ptr_q];

    assign push_ok = push_i & ~full_o;
    assign pop_ok  = pop_i & ~empty_o;

    // Depth is a power of two, so the pointers wrap naturally.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else if (clear_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            if (push_ok) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop_ok)  rd_ptr_q <= rd_ptr_q + 1'b1;
            if (push_ok && !pop_ok)      cnt_q <= cnt_q + 1'b1;
            else if (pop_ok && !push_ok) cnt_q <= cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (push_ok && !clear_i) mem_q[wr_ptr_q] <= data_i;
    end

endmodule

// File: rtl/neureka_ld_channel_arbiter.sv
// Arbitrates NB_CHAN load channels onto one memory port and routes the
// in-order responses back to the issuing channel through an ID FIFO.
module neureka_ld_channel_arbiter
    import neureka_package::*;
#(
    parameter int NB_CHAN         = 4,
    parameter int AW              = 32,
    parameter int DW              = NEUREKA_MEM_BANDWIDTH_EXT,
    parameter int MAX_OUTSTANDING = 8
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic                       clear_i,
    input  logic                       mode_i,
    input  logic [$clog2(NB_CHAN)-1:0] prio_i,
    input  logic [NB_CHAN-1:0]         ch_en_i,
    input  logic [NB_CHAN-1:0]         ch_req_i,
    input  logic [NB_CHAN*AW-1:0]      ch_add_i,
    output logic [NB_CHAN-1:0]         ch_gnt_o,
    output logic [NB_CHAN-1:0]         ch_r_valid_o,
    output logic [DW-1:0]              ch_r_data_o,
    output logic                       mem_req_o,
    output logic [AW-1:0]              mem_add_o,
    input  logic                       mem_gnt_i,
    input  logic                       mem_r_valid_i,
    input  logic [DW-1:0]              mem_r_data_i,
    output ld_arb_flags_t              flags_o
);

    localparam int CW   = $clog2(NB_CHAN);
    localparam int CNTW = $clog2(MAX_OUTSTANDING) + 1;

    arb_mode_t        mode;
    logic [NB_CHAN-1:0] elig;
    logic [CW-1:0]    start_idx, winner, rr_nxt;
    logic [CW-1:0]    rr_ptr_q, lock_idx_q, head_id;
    logic             lock_q, lock_hold, any_elig, found;
    logic             hs, fifo_full, fifo_empty, fifo_pop, err_q;
    logic [CNTW-1:0]  fifo_cnt;

    assign mode = arb_mode_t'(mode_i);

    // Clear and reset both block new requests for the cycle.
    assign elig      = ch_req_i & ch_en_i & {NB_CHAN{~(clear_i | rst_i)}};
    assign any_elig  = |elig;
    assign lock_hold = lock_q & elig[lock_idx_q];

    always_comb begin
        start_idx = rr_ptr_q;
        if (mode == ARB_FIXED) start_idx = CW'(int'(prio_i) % NB_CHAN);
    end

    // First eligible channel scanning upward from start_idx, unless a
    // stalled winner is still waiting for its grant.
    always_comb begin
        winner = start_idx;
        found  = 1'b0;
        for (int k = 0; k < NB_CHAN; k++) begin
            if (!found && elig[(int'(start_idx) + k) % NB_CHAN]) begin
                winner = CW'((int'(start_idx) + k) % NB_CHAN);
                found  = 1'b1;
            end
        end
        if (lock_hold) winner = lock_idx_q;
    end

    assign mem_req_o = any_elig & ~fifo_full;
    assign mem_add_o = mem_req_o ? ch_add_i[winner*AW +: AW] : '0;
    assign hs        = mem_req_o & mem_gnt_i;
    assign rr_nxt    = (winner == CW'(NB_CHAN - 1)) ? '0 : winner + 1'b1;

    assign fifo_pop    = mem_r_valid_i & ~fifo_empty & ~clear_i & ~rst_i;
    assign ch_r_data_o = rst_i ? '0 : mem_r_data_i;

    for (genvar i = 0; i < NB_CHAN; i++) begin : g_lane
        assign ch_gnt_o[i]     = hs & (winner == CW'(i));
        assign ch_r_valid_o[i] = fifo_pop & (head_id == CW'(i));
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            rr_ptr_q   <= '0;
            lock_q     <= 1'b0;
            lock_idx_q <= '0;
            err_q      <= 1'b0;
        end else if (clear_i) begin
            rr_ptr_q   <= '0;
            lock_q     <= 1'b0;
            lock_idx_q <= '0;
            err_q      <= 1'b0;
        end else begin
            if (hs) rr_ptr_q <= rr_nxt;
            lock_q     <= mem_req_o & ~mem_gnt_i;
            lock_idx_q <= winner;
            if (mem_r_valid_i && fifo_empty) err_q <= 1'b1;
        end
    end

    neureka_id_fifo #(
        .DEPTH (MAX_OUTSTANDING),
        .WIDTH (CW),
        .CNTW  (CNTW)
    ) i_id_fifo (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .clear_i (clear_i),
        .push_i  (hs),
        .data_i  (winner),
        .pop_i   (fifo_pop),
        .data_o  (head_id),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .count_o (fifo_cnt)
    );

    always_comb begin
        flags_o               = '0;
        flags_o.outstanding   = LD_ARB_CNT_W'(fifo_cnt);
        flags_o.fifo_empty    = fifo_empty;
        flags_o.fifo_full     = fifo_full;
        flags_o.err_underflow = err_q;
    end

endmodule

// File: tb/tb_neureka_ld_channel_arbiter.sv
// Randomized and directed bench for the load-channel arbiter with a
// behavioural model and a response scoreboard.
module tb_neureka_ld_channel_arbiter;
    import neureka_package::*;

    localparam int N  = 4;
    localparam int AW = 32;
    localparam int DW = 64;
    localparam int DEPTH = 8;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic            rst_i, clear_i, mode_i, mem_gnt_i, mem_r_valid_i;
    logic [1:0]      prio_i;
    logic [N-1:0]    ch_en_i, ch_req_i, ch_gnt_o, ch_r_valid_o;
    logic [N*AW-1:0] ch_add_i;
    logic [DW-1:0]   ch_r_data_o, mem_r_data_i;
    logic            mem_req_o;
    logic [AW-1:0]   mem_add_o;
    ld_arb_flags_t   flags_o;

    neureka_ld_channel_arbiter #(.NB_CHAN(N), .AW(AW), .DW(DW), .MAX_OUTSTANDING(DEPTH)) dut (
        .clk_i(clk), .rst_i(rst_i), .clear_i(clear_i), .mode_i(mode_i), .prio_i(prio_i),
        .ch_en_i(ch_en_i), .ch_req_i(ch_req_i), .ch_add_i(ch_add_i), .ch_gnt_o(ch_gnt_o),
        .ch_r_valid_o(ch_r_valid_o), .ch_r_data_o(ch_r_data_o), .mem_req_o(mem_req_o),
        .mem_add_o(mem_add_o), .mem_gnt_i(mem_gnt_i), .mem_r_valid_i(mem_r_valid_i),
        .mem_r_data_i(mem_r_data_i), .flags_o(flags_o)
    );

    int checks = 0;
    int errors = 0;

    // stimulus for the next cycle
    bit          t_rst, t_clr, t_mode, t_gnt, t_rv;
    int          t_prio;
    bit [N-1:0]  t_en, t_req;
    bit [AW-1:0] t_addr [N];
    bit [DW-1:0] t_rdata;

    // reference model state
    int m_rr;
    bit m_lk;
    int m_lk_idx;
    int m_q[$];
    bit m_err;
    int exp_q[$];

    // what the DUT showed in the last cycle
    logic [N-1:0]  s_gnt, s_rv;
    logic          s_req;
    logic [AW-1:0] s_add;
    ld_arb_flags_t s_flags;

    task automatic chk(input string n, input logic [63:0] a, input logic [63:0] e);
        checks++;
        if (a !== e) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", n, a, e);
        end
    endtask

    task automatic cyc();
        int w, start, c;
        bit any, e_req, hs, pop;
        bit [N-1:0] elig;
        @(negedge clk);
        rst_i = t_rst; clear_i = t_clr; mode_i = t_mode; prio_i = 2'(t_prio);
        ch_en_i = t_en; ch_req_i = t_req; mem_gnt_i = t_gnt;
        mem_r_valid_i = t_rv; mem_r_data_i = t_rdata;
        for (int i = 0; i < N; i++) ch_add_i[i*AW +: AW] = t_addr[i];
        if (t_rst) begin
            m_rr = 0; m_lk = 0; m_lk_idx = 0; m_err = 0;
            m_q.delete(); exp_q.delete();
        end
        #1;
        for (int i = 0; i < N; i++) elig[i] = t_req[i] & t_en[i] & !t_clr & !t_rst;
        start = t_mode ? m_rr : (t_prio % N);
        w = 0; any = 0;
        if (m_lk && elig[m_lk_idx]) begin
            w = m_lk_idx; any = 1;
        end else begin
            for (int k = 0; k < N; k++) begin
                c = (start + k) % N;
                if (!any && elig[c]) begin w = c; any = 1; end
            end
        end
        e_req = any && (m_q.size() < DEPTH);
        hs    = e_req && t_gnt;
        pop   = t_rv && (m_q.size() > 0) && !t_clr && !t_rst;
        chk("mem_req", 64'(mem_req_o), 64'(e_req));
        chk("mem_add", 64'(mem_add_o), e_req ? 64'(t_addr[w]) : 64'd0);
        chk("ch_gnt", 64'(ch_gnt_o), hs ? (64'd1 << w) : 64'd0);
        chk("ch_r_valid", 64'(ch_r_valid_o), pop ? (64'd1 << m_q[0]) : 64'd0);
        chk("r_data", 64'(ch_r_data_o), t_rst ? 64'd0 : 64'(t_rdata));
        chk("flags", 64'(flags_o), 64'({8'(m_q.size()), m_q.size() == 0, m_q.size() == DEPTH, m_err}));
        s_gnt = ch_gnt_o; s_rv = ch_r_valid_o; s_req = mem_req_o; s_add = mem_add_o; s_flags = flags_o;
        @(posedge clk);
        if (!t_rst) begin
            if (t_clr) begin
                m_rr = 0; m_lk = 0; m_err = 0;
                m_q.delete(); exp_q.delete();
            end else begin
                if (t_rv && m_q.size() == 0) m_err = 1;
                if (pop) void'(m_q.pop_front());
                if (hs) begin
                    m_q.push_back(w);
                    exp_q.push_back(w);
                    m_rr = (w + 1) % N;
                end
                m_lk = e_req && !t_gnt;
                m_lk_idx = w;
            end
        end
    endtask

    // response scoreboard
    initial begin
        int id;
        forever begin
            @(negedge clk);
            #2;
            if (ch_r_valid_o != '0) begin
                if (exp_q.size() == 0) begin
                    chk("rsp_unexpected", 64'(ch_r_valid_o), 64'd0);
                end else begin
                    id = exp_q.pop_front();
                    chk("rsp_id", 64'(ch_r_valid_o), 64'd1 << id);
                    chk("rsp_data", 64'(ch_r_data_o), 64'(t_rdata));
                end
            end
        end
    end

    task automatic idle();
        t_rst = 0; t_clr = 0; t_mode = 0; t_prio = 0; t_en = '1; t_req = '0;
        t_gnt = 0; t_rv = 0; t_rdata = '0;
    endtask

    task automatic do_clear();
        idle(); t_clr = 1; cyc(); t_clr = 0;
    endtask

    initial begin
        for (int i = 0; i < N; i++) t_addr[i] = 32'h1000_0000 + 32'(i) * 32'h100;
        idle();
        t_rst = 1; t_req = '1; t_gnt = 1;
        cyc(); cyc();
        chk("rst_flags", 64'(s_flags), 64'({8'd0, 1'b1, 1'b0, 1'b0}));
        chk("rst_req", 64'(s_req), 64'd0);
        chk("rst_gnt", 64'(s_gnt), 64'd0);
        idle();

        // fixed priority from ch2, continuous grants
        do_clear();
        t_mode = 0; t_prio = 2; t_req = '1; t_gnt = 1; t_rv = 1;
        for (int i = 0; i < 6; i++) begin
            cyc();
            chk("fixed_p2", 64'(s_gnt), 64'd4);
        end

        // round robin rotates through all channels
        do_clear();
        t_mode = 1; t_req = '1; t_gnt = 1; t_rv = 1;
        for (int i = 0; i < 8; i++) begin
            cyc();
            chk("rr_seq", 64'(s_gnt), 64'd1 << (i % 4));
        end

        // stalled ch1 stays locked even when higher-priority ch0 appears
        do_clear();
        t_mode = 0; t_prio = 0; t_req = 4'b0010; t_gnt = 0;
        cyc();
        t_req = 4'b0011;
        cyc(); cyc();
        chk("lock_add", 64'(s_add), 64'(t_addr[1]));
        t_gnt = 1;
        cyc();
        chk("lock_gnt", 64'(s_gnt), 64'd2);

        // fill the FIFO, then free one slot
        do_clear();
        t_mode = 1; t_req = '1; t_gnt = 1;
        for (int i = 0; i < 8; i++) cyc();
        cyc();
        chk("full_flag", 64'(s_flags.fifo_full), 64'd1);
        chk("full_req", 64'(s_req), 64'd0);
        t_rv = 1; t_rdata = 64'hdead_beef_0123_4567;
        cyc();
        chk("full_first_id", 64'(s_rv), 64'd1);
        t_rv = 0;
        cyc();
        chk("full_req_again", 64'(s_req), 64'd1);

        // underflow is sticky until clear
        do_clear();
        t_rv = 1;
        cyc();
        chk("uf_no_valid", 64'(s_rv), 64'd0);
        t_rv = 0;
        cyc();
        chk("uf_set", 64'(s_flags.err_underflow), 64'd1);
        do_clear();
        cyc();
        chk("uf_cleared", 64'(s_flags.err_underflow), 64'd0);

        // reset with IDs outstanding discards them
        do_clear();
        t_req = 4'b0001; t_gnt = 1;
        for (int i = 0; i < 5; i++) cyc();
        idle(); t_rst = 1;
        cyc();
        idle();
        cyc();
        chk("rst_mid_cnt", 64'(s_flags.outstanding), 64'd0);
        chk("rst_mid_empty", 64'(s_flags.fifo_empty), 64'd1);
        t_rv = 1;
        cyc();
        t_rv = 0;
        cyc();
        chk("rst_mid_uf", 64'(s_flags.err_underflow), 64'd1);

        // random traffic
        do_clear();
        for (int n = 0; n < 3000; n++) begin
            t_rst   = ($urandom_range(0, 299) == 0);
            t_clr   = ($urandom_range(0, 79) == 0);
            if ($urandom_range(0, 15) == 0) t_mode = ~t_mode;
            t_prio  = $urandom_range(0, 3);
            t_en    = ($urandom_range(0, 7) == 0) ? 4'($urandom) : 4'hf;
            t_req   = 4'($urandom);
            t_gnt   = ($urandom_range(0, 9) < 7);
            t_rv    = ($urandom_range(0, 99) < 35);
            t_rdata = {$urandom, $urandom};
            for (int i = 0; i < N; i++) t_addr[i] = $urandom;
            cyc();
        end

        // drain outstanding responses
        idle();
        t_rv = 1;
        for (int i = 0; i < DEPTH + 2; i++) cyc();
        chk("drain", 64'(exp_q.size()), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
